ctr3_sched: RTL and testbench
=============================

# ctr3_sched

Sequencing controller for the team's 3-bit flip-flop counter datapath (Q2..Q0). On a START request it loads a start value into the counter, then enables exactly STEPS count cycles in the selected direction. It supports pause and abort, and signals completion with a one-cycle DONE pulse. It sits between the lab-board control inputs and the counter: it drives the counter's load, data, enable and direction pins and never reads Q back.

## Interface
- WIDTH, 3: counter width; width of CNT_D and INIT.
- STEP_W, 4: step-count width; STEPS range is 0..2^STEP_W-1.

- CLK  in  1  system clock; rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  run request; sampled only in IDLE.
- HOLD  in  1  level; pauses counting while high.
- ABORT  in  1  level; cancels the run in any non-IDLE state.
- DIR  in  1  1 = count up, 0 = count down; latched at START.
- INIT  in  WIDTH  counter start value; latched at START.
- STEPS  in  STEP_W  number of count steps; latched at START.
- CNT_LD  out  1  counter synchronous load.
- CNT_D  out  WIDTH  counter load data (latched INIT).
- CNT_EN  out  1  counter count enable.
- CNT_UP  out  1  counter direction (latched DIR).
- BUSY  out  1  run in progress.
- DONE  out  1  one-cycle completion pulse.
- REMAIN  out  STEP_W  steps still to be issued.

## Operation
- Counter contract: on a CLK edge with CNT_LD=1, Q <= CNT_D. Otherwise, with CNT_EN=1, Q <= Q±1 mod 2^WIDTH. CNT_LD and CNT_EN are never both 1.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- States: IDLE, LOAD, RUN, PAUSE, FIN.
- IDLE: all strobes 0. If START=1, latch INIT, DIR and STEPS, set REMAIN=STEPS, and go to LOAD.
- LOAD: CNT_LD=1, BUSY=1.
  - ABORT=1: go to IDLE.
  - STEPS=0: go to FIN (load-only run).
  - Otherwise: go to RUN.
- RUN: CNT_EN=1, BUSY=1. Each RUN cycle issues one step, so REMAIN decrements on every RUN cycle.
  - Transition priority:
    1. REMAIN==1: go to FIN; HOLD and ABORT are ignored on this last step.
    2. ABORT: go to IDLE.
    3. HOLD: go to PAUSE.
    4. Otherwise: stay in RUN.
- PAUSE: CNT_EN=0, BUSY=1, REMAIN holds.
  - ABORT=1: go to IDLE.
  - HOLD=0: go to RUN.
- FIN: DONE=1, BUSY=0. Go to IDLE unconditionally.
- START outside IDLE is ignored. INIT, DIR and STEPS changes after acceptance have no effect on the current run.
- ABORT never produces DONE. The counter keeps its partial value. REMAIN is cleared to 0 on entry to IDLE.
- CNT_UP and CNT_D hold their latched values until the next accepted START, including while in IDLE.
- Final counter value after a completed run: INIT + STEPS (up) or INIT - STEPS (down), mod 2^WIDTH.

## Timing
- Reset (RST_N=0, takes effect immediately): state=IDLE, CNT_LD=0, CNT_D=0, CNT_EN=0, CNT_UP=0, BUSY=0, DONE=0, REMAIN=0.
- Reset mid-run returns to IDLE with no DONE pulse. The counter is not touched.
- START sampled at edge E0:
  - Cycle after E0: LOAD.
  - Next N cycles: RUN (N=STEPS, assuming no HOLD).
  - Cycle N+2 after E0: FIN, with DONE high for exactly that cycle.
- Edge-to-done latency is STEPS+2 cycles with no HOLD, and is extended by one cycle per PAUSE cycle.
- HOLD takes effect one cycle late. If HOLD is asserted during a RUN cycle, that cycle's step is still issued.
- A new START is accepted on the edge ending the FIN cycle's IDLE successor, at the earliest. START held high through FIN is sampled in the following IDLE cycle.
- STEPS=0: LOAD then FIN. DONE arrives 2 cycles after the START edge, and CNT_EN is never asserted.

## Test plan
- Reset: assert RST_N=0 mid-RUN -> all outputs 0 immediately, state IDLE, no DONE.
- Up run with wrap: INIT=5, DIR=1, STEPS=4 -> one CNT_LD cycle, then 4 CNT_EN cycles; model Q sequence 5,6,7,0,1; DONE 6 cycles after the START edge; REMAIN goes 4,3,2,1.
- Down run with pause: INIT=2, DIR=0, STEPS=5, HOLD high for 3 cycles after the 2nd RUN cycle -> exactly 5 CNT_EN pulses in total; final Q=5 (2-5 mod 8); DONE delayed by the number of PAUSE cycles.
- Abort: INIT=0, DIR=1, STEPS=7, ABORT pulsed during the 3rd RUN cycle -> 3 steps issued, Q=3, returns to IDLE, DONE never asserted, REMAIN=0.
- Load-only run: STEPS=0, INIT=6 -> CNT_LD for 1 cycle, no CNT_EN, Q=6, DONE 2 cycles after START.
- Ignored inputs: START pulsed during RUN and HOLD asserted on the last RUN cycle -> no reload, run completes normally with a single DONE pulse.

Source files
------------

// File: rtl/ctr3_sched.sv
// Sequencing controller for the 3-bit counter datapath: load a start value,
// then issue a fixed number of up/down count steps with pause/abort and a DONE pulse.
`timescale 1ns/1ps
module ctr3_sched #(
    parameter int WIDTH  = 3,
    parameter int STEP_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              hold_i,
    input  logic              abort_i,
    input  logic              dir_i,
    input  logic [WIDTH-1:0]  init_i,
    input  logic [STEP_W-1:0] steps_i,
    output logic              cnt_ld_o,
    output logic [WIDTH-1:0]  cnt_d_o,
    output logic              cnt_en_o,
    output logic              cnt_up_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [STEP_W-1:0] remain_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   remain_q, remain_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                up_q, up_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            remain_q <= '0;
            data_q   <= '0;
            up_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            data_q   <= data_d;
            up_q     <= up_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        data_d   = data_q;
        up_d     = up_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    data_d   = init_i;
                    up_d     = dir_i;
                    remain_d = steps_i;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (abort_i) begin
                    state_d  = IDLE;
                    remain_d = '0;
                end else if (remain_q == '0) begin
                    state_d = FIN;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // The step of this cycle is issued regardless of HOLD/ABORT.
                remain_d = remain_q - STEP_W'(1);
                if (remain_q == STEP_W'(1)) begin
                    state_d = FIN;
                end else if (abort_i) begin
                    state_d  = IDLE;
                    remain_d = '0;
                end else if (hold_i) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (abort_i) begin
                    state_d  = IDLE;
                    remain_d = '0;
                end else if (!hold_i) begin
                    state_d = RUN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                remain_d = '0;
            end
        endcase
    end

    // Every output is decoded from registered state only.
    assign cnt_ld_o = (state_q == LOAD);
    assign cnt_en_o = (state_q == RUN);
    assign busy_o   = (state_q == LOAD) || (state_q == RUN) || (state_q == PAUSE);
    assign done_o   = (state_q == FIN);
    assign cnt_d_o  = data_q;
    assign cnt_up_o = up_q;
    assign remain_o = remain_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_ctr3_sched.sv
// Directed bench for ctr3_sched: vector table of whole runs plus hand sequences
// for reset mid-run and START held through FIN. Models the external counter.
`timescale 1ns/1ps
module tb_ctr3_sched;

    localparam int WIDTH  = 3;
    localparam int STEP_W = 4;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam int NV = 12;

    logic              clk;
    logic              rst_n;
    logic              start, hold, abort, dir;
    logic [WIDTH-1:0]  init;
    logic [STEP_W-1:0] steps;
    logic              cnt_ld_o, cnt_en_o, cnt_up_o, busy_o, done_o;
    logic [WIDTH-1:0]  cnt_d_o;
    logic [STEP_W-1:0] remain_o;
    logic [2:0]        state_o;

    logic [WIDTH-1:0]  q_model = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0]  init;
        logic              dir;
        logic [STEP_W-1:0] steps;
        int                hold_from;
        int                hold_to;
        int                abort_at;
        int                start_at;
        int                exp_end;
        logic              exp_done;
        int                exp_en;
        logic [WIDTH-1:0]  exp_q;
    } vec_t;

    vec_t vecs[NV];

    ctr3_sched #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start),
        .hold_i   (hold),
        .abort_i  (abort),
        .dir_i    (dir),
        .init_i   (init),
        .steps_i  (steps),
        .cnt_ld_o (cnt_ld_o),
        .cnt_d_o  (cnt_d_o),
        .cnt_en_o (cnt_en_o),
        .cnt_up_o (cnt_up_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .remain_o (remain_o),
        .state_o  (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External counter as the lab board sees it.
    always @(posedge clk) begin
        if (cnt_ld_o)
            q_model <= cnt_d_o;
        else if (cnt_en_o)
            q_model <= cnt_up_o ? q_model + 3'd1 : q_model - 3'd1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int en_cnt;
        en_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; init = v.init; dir = v.dir; steps = v.steps;
        hold = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= v.exp_end; c++) begin
            start = (c == v.start_at);
            hold  = (c >= v.hold_from) && (c <= v.hold_to);
            abort = (c == v.abort_at);
            init  = WIDTH'($urandom_range(0, 7));
            dir   = 1'($urandom_range(0, 1));
            steps = STEP_W'($urandom_range(0, 15));
            check($sformatf("v%0d c%0d busy", idx, c), busy_o, (c < v.exp_end) ? 1 : 0);
            check($sformatf("v%0d c%0d done", idx, c), done_o,
                  (c == v.exp_end && v.exp_done) ? 1 : 0);
            check($sformatf("v%0d c%0d ld", idx, c), cnt_ld_o, (c == 1) ? 1 : 0);
            check($sformatf("v%0d c%0d remain", idx, c), remain_o,
                  (c == v.exp_end) ? 0 : int'(v.steps) - en_cnt);
            if (cnt_en_o) en_cnt++;
            if (c < v.exp_end) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0; hold = 1'b0; abort = 1'b0;
        check($sformatf("v%0d en_pulses", idx), en_cnt, v.exp_en);
        check($sformatf("v%0d final_q", idx), q_model, v.exp_q);
        check($sformatf("v%0d cnt_d", idx), cnt_d_o, v.init);
        check($sformatf("v%0d cnt_up", idx), cnt_up_o, v.dir);
        if (v.exp_done) begin
            @(posedge clk); #1;
            check($sformatf("v%0d done_pulse_end", idx), done_o, 0);
        end
        check($sformatf("v%0d idle", idx), state_o, S_IDLE);
    endtask

    initial begin
        // init dir steps  hfrom hto abort start  end done en  q
        vecs[0]  = '{3'd5, 1'b1, 4'd4,  0, 0, 0, 0,  6, 1'b1, 4,  3'd1};
        vecs[1]  = '{3'd2, 1'b0, 4'd5,  0, 0, 0, 0,  7, 1'b1, 5,  3'd5};
        vecs[2]  = '{3'd2, 1'b0, 4'd5,  4, 6, 0, 0, 10, 1'b1, 5,  3'd5};
        vecs[3]  = '{3'd6, 1'b1, 4'd0,  0, 0, 0, 0,  2, 1'b1, 0,  3'd6};
        vecs[4]  = '{3'd0, 1'b1, 4'd7,  0, 0, 4, 0,  5, 1'b0, 3,  3'd3};
        vecs[5]  = '{3'd4, 1'b1, 4'd3,  4, 4, 0, 3,  5, 1'b1, 3,  3'd7};
        vecs[6]  = '{3'd1, 1'b0, 4'd2,  0, 0, 3, 0,  4, 1'b1, 2,  3'd7};
        vecs[7]  = '{3'd0, 1'b1, 4'd15, 0, 0, 0, 0, 17, 1'b1, 15, 3'd7};
        vecs[8]  = '{3'd3, 1'b0, 4'd15, 0, 0, 0, 0, 17, 1'b1, 15, 3'd4};
        vecs[9]  = '{3'd3, 1'b1, 4'd6,  3, 5, 5, 0,  6, 1'b0, 2,  3'd5};
        vecs[10] = '{3'd6, 1'b0, 4'd5,  0, 0, 1, 0,  2, 1'b0, 0,  3'd6};
        vecs[11] = '{3'd7, 1'b1, 4'd1,  0, 0, 0, 0,  3, 1'b1, 1,  3'd0};

        rst_n = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0; dir = 1'b0;
        init = '0; steps = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst state", state_o, S_IDLE);
        check("rst busy", busy_o, 0);
        check("rst done", done_o, 0);
        check("rst ld_en", {cnt_ld_o, cnt_en_o}, 0);
        check("rst cnt_d", cnt_d_o, 0);
        check("rst cnt_up", cnt_up_o, 0);
        check("rst remain", remain_o, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Reset mid-run: outputs clear at once, counter keeps its value.
        @(posedge clk); #1;
        start = 1'b1; init = 3'd5; dir = 1'b1; steps = 4'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst busy_before", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst state", state_o, S_IDLE);
        check("midrst busy", busy_o, 0);
        check("midrst en", cnt_en_o, 0);
        check("midrst cnt_d", cnt_d_o, 0);
        check("midrst cnt_up", cnt_up_o, 0);
        check("midrst remain", remain_o, 0);
        @(posedge clk); #1;
        check("midrst done", done_o, 0);
        check("midrst q", q_model, 7);
        rst_n = 1'b1;

        // START held high through FIN is taken in the following IDLE cycle.
        @(posedge clk); #1;
        start = 1'b1; init = 3'd2; dir = 1'b1; steps = 4'd1;
        @(posedge clk); #1;
        check("held c1 ld", cnt_ld_o, 1);
        @(posedge clk); #1;
        check("held c2 en", cnt_en_o, 1);
        @(posedge clk); #1;
        check("held c3 done", done_o, 1);
        @(posedge clk); #1;
        check("held c4 state", state_o, S_IDLE);
        check("held c4 done", done_o, 0);
        @(posedge clk); #1;
        check("held c5 state", state_o, S_LOAD);
        start = 1'b0;
        @(posedge clk); #1;
        check("held c6 en", cnt_en_o, 1);
        @(posedge clk); #1;
        check("held c7 done", done_o, 1);
        @(posedge clk); #1;
        check("held c8 q", q_model, 3);
        check("held c8 state", state_o, S_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
